// File: rtl/frmbuf_pkg.sv
// frmbuf_pkg
//   Shared definitions for the frame-buffer DDR3 arbiter slice:
//   arbiter state encoding, MIG command codes and default bus widths.
//   No ports; imported by frmbuf_rr_pick and frmbuf_arb_rr.
package frmbuf_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_PROC = 2'd2,
        S_GAP  = 2'd3
    } arb_state_t;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    localparam int unsigned DEF_ADDR_W = 27;
    localparam int unsigned DEF_DATA_W = 256;

endpackage

// File: rtl/frmbuf_rr_pick.sv
// frmbuf_rr_pick
//   Combinational round-robin search. Scans the request vector starting at
//   (last + 1) mod P_CH_NUM, wrapping, and reports the first set bit.
// Ports:
//   request  in  P_CH_NUM          request vector
//   last     in  $clog2(P_CH_NUM)  last granted channel
//   found    out 1                 at least one request set
//   winner   out $clog2(P_CH_NUM)  index of the winning channel
module frmbuf_rr_pick
    import frmbuf_pkg::*;
#(
    parameter int unsigned P_CH_NUM = 4
)(
    input  logic [P_CH_NUM-1:0]         request,
    input  logic [$clog2(P_CH_NUM)-1:0] last,
    output logic                        found,
    output logic [$clog2(P_CH_NUM)-1:0] winner
);

    localparam int unsigned CH_W = $clog2(P_CH_NUM);

    logic [CH_W-1:0] cand;

    // Walk offsets from P_CH_NUM (= last itself) down to 1 so that the
    // requester nearest after last is the final one written.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 0; i < P_CH_NUM; i++) begin
            cand = CH_W'((32'(last) + P_CH_NUM - i) % P_CH_NUM);
            if (request[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/frmbuf_arb_rr.sv
// frmbuf_arb_rr
//   N-channel round-robin arbiter between frame-buffer clients and the DDR3
//   MIG user interface. A granted channel drives commands straight through
//   to the MIG until it strobes burst end; a one-cycle gap then precedes the
//   next arbitration. Optional burst watchdog: define FRMBUF_ARB_WDOG_EN.
// Ports:
//   i_ddr3_clk, i_rst_n        clock, async active-low reset
//   i_system_init              calibration done; low forces idle
//   i_request / o_response     per-channel request / one-hot registered grant
//   i_bust_end                 per-channel last-command strobe
//   i_req_addr, i_cmd_valid, i_rdwr_cmd   per-channel command inputs
//   i_app_rdy, i_app_wdf_rdy   MIG ready flags
//   i_wr_en, i_wr_data         shared write FIFO output
//   o_wrfifo_rd                write FIFO pop
//   o_app_en/cmd/addr          MIG command port
//   o_app_wdf_wren/data        MIG write data port
//   o_cur_ch                   registered granted channel index
//   o_tmo_err                  sticky watchdog flag
module frmbuf_arb_rr
    import frmbuf_pkg::*;
#(
    parameter int unsigned P_CH_NUM  = 4,
    parameter int unsigned P_ADDR_W  = DEF_ADDR_W,
    parameter int unsigned P_DATA_W  = DEF_DATA_W,
    parameter int unsigned P_CMD_W   = 3,
    parameter int unsigned P_TMO_W   = 16,
    parameter int unsigned P_TMO_MAX = 16'hFFFF
)(
    input  logic                           i_ddr3_clk,
    input  logic                           i_rst_n,
    input  logic                           i_system_init,
    input  logic [P_CH_NUM-1:0]            i_request,
    output logic [P_CH_NUM-1:0]            o_response,
    input  logic [P_CH_NUM-1:0]            i_bust_end,
    input  logic [P_CH_NUM*P_ADDR_W-1:0]   i_req_addr,
    input  logic [P_CH_NUM-1:0]            i_cmd_valid,
    input  logic [P_CH_NUM*P_CMD_W-1:0]    i_rdwr_cmd,
    input  logic                           i_app_rdy,
    input  logic                           i_app_wdf_rdy,
    input  logic                           i_wr_en,
    input  logic [P_DATA_W-1:0]            i_wr_data,
    output logic                           o_wrfifo_rd,
    output logic                           o_app_en,
    output logic [P_CMD_W-1:0]             o_app_cmd,
    output logic [P_ADDR_W-1:0]            o_app_addr,
    output logic                           o_app_wdf_wren,
    output logic [P_DATA_W-1:0]            o_app_wdf_data,
    output logic [$clog2(P_CH_NUM)-1:0]    o_cur_ch,
    output logic                           o_tmo_err
);

    localparam int unsigned CH_W = $clog2(P_CH_NUM);

    arb_state_t          state;
    logic [CH_W-1:0]     last_ptr;
    logic                pick_found;
    logic [CH_W-1:0]     pick_idx;
    logic [P_CH_NUM-1:0] pick_onehot;
    logic                in_proc;
    logic                tmo_hit;

    logic                g_cmd_valid;
    logic                g_bust_end;
    logic [P_CMD_W-1:0]  g_cmd;
    logic [P_ADDR_W-1:0] g_addr;

    frmbuf_rr_pick #(
        .P_CH_NUM (P_CH_NUM)
    ) u_pick (
        .request (i_request),
        .last    (last_ptr),
        .found   (pick_found),
        .winner  (pick_idx)
    );

    assign pick_onehot = {{(P_CH_NUM-1){1'b0}}, 1'b1} << pick_idx;
    assign in_proc     = (state == S_PROC);

    // Select the granted channel's command inputs.
    always_comb begin
        g_cmd_valid = 1'b0;
        g_bust_end  = 1'b0;
        g_cmd       = '0;
        g_addr      = '0;
        for (int unsigned k = 0; k < P_CH_NUM; k++) begin
            if (o_cur_ch == CH_W'(k)) begin
                g_cmd_valid = i_cmd_valid[k];
                g_bust_end  = i_bust_end[k];
                g_cmd       = i_rdwr_cmd[k*P_CMD_W +: P_CMD_W];
                g_addr      = i_req_addr[k*P_ADDR_W +: P_ADDR_W];
            end
        end
    end

    assign o_app_en       = in_proc & g_cmd_valid;
    assign o_app_cmd      = in_proc ? g_cmd  : '0;
    assign o_app_addr     = in_proc ? g_addr : '0;
    assign o_app_wdf_wren = i_wr_en & in_proc;
    assign o_app_wdf_data = i_wr_data;
    assign o_wrfifo_rd    = o_app_wdf_wren & i_app_wdf_rdy;

    always_ff @(posedge i_ddr3_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            o_response <= '0;
            o_cur_ch   <= '0;
            last_ptr   <= CH_W'(P_CH_NUM - 1);
        end else if (!i_system_init) begin
            state      <= S_IDLE;
            o_response <= '0;
        end else begin
            case (state)
                S_IDLE: state <= S_ARB;
                S_ARB: begin
                    if (pick_found) begin
                        state      <= S_PROC;
                        o_response <= pick_onehot;
                        o_cur_ch   <= pick_idx;
                        last_ptr   <= pick_idx;
                    end
                end
                S_PROC: begin
                    if (g_bust_end || tmo_hit) begin
                        state      <= S_GAP;
                        o_response <= '0;
                    end
                end
                S_GAP:   state <= S_ARB;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FRMBUF_ARB_WDOG_EN
    localparam logic [P_TMO_W-1:0] TMO_LAST = P_TMO_W'(P_TMO_MAX - 1);

    logic [P_TMO_W-1:0] tmo_cnt;
    logic               tmo_inc;

    // Stalls caused by the MIG (valid command, app_rdy low) do not count.
    assign tmo_inc = !g_cmd_valid || i_app_rdy;
    assign tmo_hit = in_proc && !g_bust_end && tmo_inc && (tmo_cnt == TMO_LAST);

    // Clearing during S_ARB guarantees a zero count on every entry to S_PROC.
    always_ff @(posedge i_ddr3_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt   <= '0;
            o_tmo_err <= 1'b0;
        end else begin
            if (state == S_ARB) begin
                tmo_cnt <= '0;
            end else if (in_proc && tmo_inc) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (tmo_hit && i_system_init) begin
                o_tmo_err <= 1'b1;
            end
        end
    end
`else
    localparam int unsigned unused_tmo_cfg = P_TMO_W + P_TMO_MAX;
    logic unused_app_rdy;

    assign unused_app_rdy = i_app_rdy;
    assign tmo_hit        = 1'b0;
    assign o_tmo_err      = 1'b0;
`endif

endmodule
